// File: rtl/var_state_table_pkg.sv
// Shared opcode, bank and FSM state encodings for the variable-state table.
package var_table_pkg;

  localparam logic [2:0] OP_READ      = 3'd0;
  localparam logic [2:0] OP_WRITE     = 3'd1;
  localparam logic [2:0] OP_ASSIGN    = 3'd2;
  localparam logic [2:0] OP_UNASSIGN  = 3'd3;
  localparam logic [2:0] OP_FIND_FREE = 3'd4;
  localparam logic [2:0] OP_CLEAR     = 3'd5;

  localparam logic [1:0] BANK_VALUE    = 2'd0;
  localparam logic [1:0] BANK_FREE     = 2'd1;
  localparam logic [1:0] BANK_ASSIGNED = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RESP = 2'd1;
  localparam logic [1:0] ST_SCAN = 2'd2;

endpackage

// File: rtl/var_state_table_first_one_enc.sv
// Combinational lowest-set-bit encoder with an any-set flag.
module first_one_enc #(
  parameter int unsigned WORD_W = 8,
  localparam int unsigned IW = (WORD_W > 1) ? $clog2(WORD_W) : 1
) (
  input  logic [WORD_W-1:0] word,
  output logic [IW-1:0]     idx_c,
  output logic              any_c
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    idx_c = '0;
    any_c = 1'b0;
    for (int i = int'(WORD_W) - 1; i >= 0; i--) begin
      if (word[i]) begin
        idx_c = IW'(i);
        any_c = 1'b1;
      end
    end
  end

endmodule

// File: rtl/var_state_table.sv
// Variable-state store (VALUE/FREE/ASSIGNED banks) with assign/unassign,
// conflict detection, word access, soft clear and a first-free-variable scan.
module var_state_table
  import var_table_pkg::*;
#(
  parameter int unsigned NUM_VARS = 8,
  parameter int unsigned WORD_W = 8,
  parameter logic [NUM_VARS-1:0] FREE_INIT = {NUM_VARS{1'b1}},
  localparam int unsigned NUM_WORDS = (NUM_VARS + WORD_W - 1) / WORD_W,
  localparam int unsigned AW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1,
  localparam int unsigned VW = (NUM_VARS > 1) ? $clog2(NUM_VARS) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [2:0]        cmd_op,
  input  logic [1:0]        cmd_bank,
  input  logic [AW-1:0]     cmd_addr,
  input  logic [VW-1:0]     cmd_var,
  input  logic              cmd_val,
  input  logic [WORD_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  output logic [WORD_W-1:0] rsp_data,
  output logic              rsp_found,
  output logic              rsp_conflict,
  output logic              rsp_error
);

  localparam int unsigned TOT = NUM_WORDS * WORD_W;
  localparam int unsigned IW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  // Padding bits above NUM_VARS are held at zero in every bank.
  localparam logic [TOT-1:0] VALID_MASK = TOT'({NUM_VARS{1'b1}});
  localparam logic [TOT-1:0] FREE_IMG = TOT'(FREE_INIT);

  logic [1:0]        state_q, state_d;
  logic [AW-1:0]     scan_q, scan_d;
  logic [TOT-1:0]    val_q, val_d, free_q, free_d, asg_q, asg_d;
  logic              rsp_valid_d, found_d, conflict_d, error_d;
  logic [WORD_W-1:0] data_d;

  logic [TOT-1:0]    sel_bank, wr_img;
  logic              bank_ok, addr_ok, var_ok, last_word;
  logic [WORD_W-1:0] scan_word;
  logic [IW-1:0]     enc_idx;
  logic              enc_any;

  assign addr_ok   = 32'(cmd_addr) < NUM_WORDS;
  assign var_ok    = 32'(cmd_var) < NUM_VARS;
  assign last_word = 32'(scan_q) == (NUM_WORDS - 1);
  assign scan_word = free_q[WORD_W*scan_q +: WORD_W];

  first_one_enc #(.WORD_W(WORD_W)) u_enc (
    .word  (scan_word),
    .idx_c (enc_idx),
    .any_c (enc_any)
  );

  // Bank selection and the masked write image for word-level access.
  always_comb begin
    bank_ok  = 1'b1;
    sel_bank = '0;
    case (cmd_bank)
      BANK_VALUE:    sel_bank = val_q;
      BANK_FREE:     sel_bank = free_q;
      BANK_ASSIGNED: sel_bank = asg_q;
      default:       bank_ok  = 1'b0;
    endcase
    wr_img = sel_bank;
    if (addr_ok) wr_img[WORD_W*cmd_addr +: WORD_W] = cmd_wdata;
    wr_img = wr_img & VALID_MASK;
  end

  // Next-state, table update and response logic.
  always_comb begin
    state_d     = state_q;
    scan_d      = scan_q;
    val_d       = val_q;
    free_d      = free_q;
    asg_d       = asg_q;
    rsp_valid_d = 1'b0;
    data_d      = rsp_data;
    found_d     = rsp_found;
    conflict_d  = rsp_conflict;
    error_d     = rsp_error;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_op == OP_FIND_FREE) begin
          state_d = ST_SCAN;
          scan_d  = '0;
        end else if (cmd_valid) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          data_d      = '0;
          found_d     = 1'b0;
          conflict_d  = 1'b0;
          error_d     = 1'b0;
          case (cmd_op)
            OP_READ: begin
              if (bank_ok && addr_ok) data_d = sel_bank[WORD_W*cmd_addr +: WORD_W];
              else error_d = 1'b1;
            end
            OP_WRITE: begin
              if (bank_ok && addr_ok) begin
                case (cmd_bank)
                  BANK_VALUE: val_d  = wr_img;
                  BANK_FREE:  free_d = wr_img;
                  default:    asg_d  = wr_img;
                endcase
              end else begin
                error_d = 1'b1;
              end
            end
            OP_ASSIGN: begin
              if (!var_ok) error_d = 1'b1;
              else if (asg_q[cmd_var] && (val_q[cmd_var] != cmd_val)) conflict_d = 1'b1;
              else begin
                val_d[cmd_var]  = cmd_val;
                asg_d[cmd_var]  = 1'b1;
                free_d[cmd_var] = 1'b0;
              end
            end
            OP_UNASSIGN: begin
              if (var_ok) begin
                asg_d[cmd_var]  = 1'b0;
                free_d[cmd_var] = FREE_IMG[cmd_var];
              end else begin
                error_d = 1'b1;
              end
            end
            OP_CLEAR: begin
              val_d  = '0;
              asg_d  = '0;
              free_d = FREE_IMG;
            end
            default: error_d = 1'b1;
          endcase
        end
      end
      ST_RESP: state_d = ST_IDLE;
      ST_SCAN: begin
        if (enc_any || last_word) begin
          state_d     = ST_RESP;
          rsp_valid_d = 1'b1;
          found_d     = enc_any;
          conflict_d  = 1'b0;
          error_d     = 1'b0;
          data_d      = enc_any ? WORD_W'(32'(scan_q) * WORD_W + 32'(enc_idx)) : '0;
        end else begin
          scan_d = scan_q + AW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      scan_q       <= '0;
      val_q        <= '0;
      free_q       <= FREE_IMG;
      asg_q        <= '0;
      cmd_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_data     <= '0;
      rsp_found    <= 1'b0;
      rsp_conflict <= 1'b0;
      rsp_error    <= 1'b0;
    end else begin
      state_q      <= state_d;
      scan_q       <= scan_d;
      val_q        <= val_d;
      free_q       <= free_d;
      asg_q        <= asg_d;
      cmd_ready    <= (state_d == ST_IDLE);
      rsp_valid    <= rsp_valid_d;
      rsp_data     <= data_d;
      rsp_found    <= found_d;
      rsp_conflict <= conflict_d;
      rsp_error    <= error_d;
    end
  end

endmodule
